// File: rtl/mac_pkg.sv
// mac_pkg: constants and types shared by the MAC array and its downstream stages.
//   MAC_DIM / MAC_IN_W / MAC_ACC_W : array geometry and element widths
//   acc_mat_t                      : DIM x DIM signed accumulator matrix, [row][col]
//   drain_state_e                  : result-drain FSM states
package mac_pkg;

  localparam int unsigned MAC_DIM   = 4;
  localparam int unsigned MAC_IN_W  = 8;
  localparam int unsigned MAC_ACC_W = 32;

  typedef logic signed [MAC_DIM-1:0][MAC_DIM-1:0][MAC_ACC_W-1:0] acc_mat_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/mac_result_drain_sat_clamp.sv
// sat_clamp: combinational signed narrowing with saturation.
//   din     in  IN_W  signed value
//   dout    out OUT_W signed value, clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   clamped out 1     high when din did not fit and was clamped
// OUT_W == IN_W is a pass-through with clamped tied low.
module sat_clamp #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamped
);

  if (OUT_W == IN_W) begin : g_pass
    assign dout    = din;
    assign clamped = 1'b0;
  end else begin : g_narrow
    // The value fits when every bit from the output sign bit upwards
    // matches, i.e. they are all ones or all zeros.
    logic [IN_W-OUT_W:0] upper;
    logic                fits;
    logic [OUT_W-1:0]    min_v;
    logic [OUT_W-1:0]    max_v;

    assign upper = din[IN_W-1:OUT_W-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
      min_v            = '0;
      min_v[OUT_W-1]   = 1'b1;
      max_v            = ~min_v;
      if (fits) begin
        dout = din[OUT_W-1:0];
      end else if (din[IN_W-1]) begin
        dout = min_v;
      end else begin
        dout = max_v;
      end
      clamped = ~fits;
    end
  end

endmodule

// File: rtl/mac_result_drain.sv
// mac_result_drain: snapshots the DIM x DIM accumulator matrix on a capture
// pulse and streams it out row-major on a valid/ready master stream.
//   clk, rst_n          clock / async active-low reset
//   capture             snapshot request (accepted in IDLE or on the last-beat handshake)
//   acc                 accumulator matrix [row][col], ACC_W signed each
//   busy                high while draining
//   overrun             one-cycle pulse when a capture is dropped
//   m_tvalid/m_tready   stream handshake
//   m_tdata             element value, saturated to OUT_W
//   m_tlast             final element [DIM-1][DIM-1]
//   m_tuser             this beat's value was clamped
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int unsigned DIM   = MAC_DIM,
  parameter int unsigned ACC_W = MAC_ACC_W,
  parameter int unsigned OUT_W = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    capture,
  input  logic signed [DIM-1:0][DIM-1:0][ACC_W-1:0] acc,
  output logic                                    busy,
  output logic                                    overrun,
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic signed [OUT_W-1:0]                 m_tdata,
  output logic                                    m_tlast,
  output logic                                    m_tuser
);

  localparam int unsigned NUM   = DIM * DIM;
  localparam int unsigned IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

  drain_state_e          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM*ACC_W-1:0]  snap_q;
  logic                  load_snap;
  logic                  overrun_q, overrun_d;
  logic                  hs, last_hs;
  logic signed [ACC_W-1:0] elem;
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_flag;

  assign hs      = (state_q == DRAIN) && m_tready;
  assign last_hs = hs && (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (load_snap) begin
        snap_q <= acc;
      end
    end
  end

  // A capture coinciding with the last-beat handshake reloads the snapshot
  // and restarts at index 0 without leaving DRAIN, so tiles chain with no bubble.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_snap = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d   = DRAIN;
          idx_d     = '0;
          load_snap = 1'b1;
        end
      end
      DRAIN: begin
        if (last_hs) begin
          idx_d = '0;
          if (capture) begin
            load_snap = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + 1'b1;
          end
          if (capture) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packed [row][col] layout places element i = row*DIM+col at bit i*ACC_W.
  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        elem = snap_q[i*ACC_W +: ACC_W];
      end
    end
  end

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din     (elem),
    .dout    (sat_data),
    .clamped (sat_flag)
  );

  assign m_tvalid = (state_q == DRAIN);
  assign busy     = (state_q == DRAIN);
  assign m_tlast  = m_tvalid && (idx_q == LAST_IDX);
  assign m_tdata  = m_tvalid ? sat_data : '0;
  assign m_tuser  = m_tvalid && sat_flag;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

  logic                          clk;
  logic                          rst_n;
  logic                          capture;
  logic signed [3:0][3:0][31:0]  acc;
  logic                          m_tready;

  logic               busy, overrun, m_tvalid, m_tlast, m_tuser;
  logic signed [31:0] m_tdata;
  logic               d8_busy, d8_overrun, d8_tvalid, d8_tlast, d8_tuser;
  logic signed [7:0]  d8_tdata;

  mac_result_drain #(.DIM(4), .ACC_W(32), .OUT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .capture(capture), .acc(acc),
    .busy(busy), .overrun(overrun),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tuser(m_tuser)
  );

  mac_result_drain #(.DIM(4), .ACC_W(32), .OUT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .capture(capture), .acc(acc),
    .busy(d8_busy), .overrun(d8_overrun),
    .m_tvalid(d8_tvalid), .m_tready(m_tready), .m_tdata(d8_tdata),
    .m_tlast(d8_tlast), .m_tuser(d8_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] d32;
    logic signed [7:0]  d8;
    logic               u8;
    logic               last;
  } beat_t;

  beat_t q[$];
  int    n_vec  = 0;
  int    n_err  = 0;
  logic  ov_exp = 1'b0;
  int    hs_cnt = 0;
  int    v_cnt  = 0;
  int    ov_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, $signed(got), $signed(exp), $time);
    end
  endtask

  task automatic push_tile();
    int    v;
    beat_t b;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        v     = $signed(acc[r][c]);
        b.d32 = v;
        if (v > 127) begin
          b.d8 = 8'sd127; b.u8 = 1'b1;
        end else if (v < -128) begin
          b.d8 = -8'sd128; b.u8 = 1'b1;
        end else begin
          b.d8 = v[7:0]; b.u8 = 1'b0;
        end
        b.last = (r == 3) && (c == 3);
        q.push_back(b);
      end
    end
  endtask

  // Called at the falling edge: compare outputs against the scoreboard head,
  // then advance the transaction model for the coming rising edge.
  task automatic sample();
    beat_t e;
    logic  exp_valid, hs, last_hs;
    e = '{0, 0, 1'b0, 1'b0};
    exp_valid = (q.size() != 0);
    chk("tvalid",  {31'b0, m_tvalid},  {31'b0, exp_valid});
    chk("busy",    {31'b0, busy},      {31'b0, exp_valid});
    chk("overrun", {31'b0, overrun},   {31'b0, ov_exp});
    chk("tvalid8", {31'b0, d8_tvalid}, {31'b0, exp_valid});
    if (exp_valid) begin
      e = q[0];
      chk("tdata",  m_tdata,            e.d32);
      chk("tlast",  {31'b0, m_tlast},   {31'b0, e.last});
      chk("tuser",  {31'b0, m_tuser},   32'd0);
      chk("tdata8", {{24{d8_tdata[7]}}, d8_tdata}, {{24{e.d8[7]}}, e.d8});
      chk("tuser8", {31'b0, d8_tuser},  {31'b0, e.u8});
    end
    if (m_tvalid && m_tready) hs_cnt++;
    if (m_tvalid) v_cnt++;
    if (overrun) ov_cnt++;
    hs      = exp_valid && m_tready;
    last_hs = hs && e.last;
    if (hs) void'(q.pop_front());
    ov_exp = 1'b0;
    if (capture && rst_n) begin
      if (!exp_valid || last_hs) push_tile();
      else ov_exp = 1'b1;
    end
  endtask

  task automatic cyc(input logic cap, input logic rdy);
    capture  = cap;
    m_tready = rdy;
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        acc[r][c] = 32'(r * 4 + c + 1);
  endtask

  task automatic load_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        acc[r][c] = 32'(int'($urandom_range(0, 4000)) - 2000);
  endtask

  initial begin
    rst_n = 1'b0; capture = 1'b0; m_tready = 1'b0; acc = '0;
    #1;
    chk("rst_tvalid",  {31'b0, m_tvalid}, 32'd0);
    chk("rst_busy",    {31'b0, busy},     32'd0);
    chk("rst_overrun", {31'b0, overrun},  32'd0);
    chk("rst_tlast",   {31'b0, m_tlast},  32'd0);
    chk("rst_tuser",   {31'b0, m_tuser},  32'd0);
    chk("rst_tdata",   m_tdata,           32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);

    // Basic drain, tready held high: exactly 16 valid cycles.
    load_basic();
    v_cnt = 0;
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 18; k++) cyc(1'b0, 1'b1);
    chk("basic_valid_cycles", v_cnt, 32'd16);

    // Backpressure: tready 1,0,0,1 repeating.
    hs_cnt = 0;
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 70; k++) cyc(1'b0, (k % 4 == 0) || (k % 4 == 3));
    chk("bp_handshakes", hs_cnt, 32'd16);
    chk("bp_queue_empty", q.size(), 32'd0);

    // Saturation to 8 bits, including exact boundaries.
    load_random();
    acc[0][0] = 32'sd300;  acc[0][1] = -32'sd200;
    acc[0][2] = 32'sd12;   acc[0][3] = -32'sd10;
    acc[1][0] = 32'sd127;  acc[1][1] = -32'sd128;
    acc[1][2] = 32'sd128;  acc[1][3] = -32'sd129;
    cyc(1'b1, 1'b1);
    acc = '0;
    for (int k = 0; k < 18; k++) cyc(1'b0, 1'b1);

    // Overrun at beat 5, then back-to-back capture on the last handshake.
    load_basic();
    ov_cnt = 0;
    cyc(1'b1, 1'b1);
    load_random();
    for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    load_basic();
    for (int k = 0; k < 18; k++) cyc(1'b0, 1'b1);
    chk("overrun_pulses", ov_cnt, 32'd1);

    // Async reset while beat 7 is stalled.
    load_basic();
    cyc(1'b1, 1'b1);
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("arst_busy",   {31'b0, busy},     32'd0);
    chk("arst_tlast",  {31'b0, m_tlast},  32'd0);
    q.delete();
    ov_exp = 1'b0;
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0);
    for (int k = 0; k < 18; k++) cyc(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
